// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int N_REQ_DEF     = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int MAX_BURST_DEF = 4;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit at or after ptr, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     any,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] cand;

  // Scan farthest-first so the closest hit to ptr is the last one written.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among N_REQ
// valid/ready producers, with bounded bursts and full-flag backpressure.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_wr_en,
  output logic [DATA_W-1:0]          fifo_data_in,
  output logic                       grant_valid,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_e        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [CNT_W-1:0]  beat_cnt;

  logic              pick_any;
  logic [IDX_W-1:0]  pick_idx;
  logic              in_burst;
  logic              g_valid;
  logic [DATA_W-1:0] g_data;
  logic              beat;
  logic              burst_done;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign in_burst   = (state == BURST);
  assign g_valid    = req_valid[grant_id];
  assign g_data     = req_data[int'(grant_id) * DATA_W +: DATA_W];
  assign beat       = in_burst & g_valid & ~fifo_full;
  // A grant ends on its last counted beat or as soon as the grantee drops valid.
  assign burst_done = in_burst & ((beat & (beat_cnt == LAST_BEAT)) | ~g_valid);

  always_comb begin
    req_ready = '0;
    if (in_burst && !fifo_full) req_ready[grant_id] = 1'b1;
  end

  assign fifo_wr_en   = beat;
  assign fifo_data_in = beat ? g_data : '0;
  assign grant_valid  = in_burst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state    <= BURST;
            grant_id <= pick_idx;
            beat_cnt <= '0;
          end
        end
        BURST: begin
          if (burst_done) begin
            state    <= IDLE;
            rr_ptr   <= grant_id + 1'b1;
            beat_cnt <= '0;
          end else if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producer queues feed the DUT, per-cycle
// outputs are logged mid-cycle and compared against hand-derived traces.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_data_in;
  logic            grant_valid;
  logic [1:0]      grant_id;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .N_REQ     (N),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] pdat[N][8];
  int         plen[N];
  int         phead[N];
  logic       full_pat[32];

  logic [8:0] lg_wr[32];
  logic       lg_gv[32];
  logic [1:0] lg_gid[32];
  logic [1:0] lg_ptr[32];
  logic [3:0] lg_rdy[32];

  int e9[9];
  int e17[17];
  int ev9[9];
  int cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int c);
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = (phead[i] < plen[i]);
      req_data[i*DW +: DW]  = (phead[i] < plen[i]) ? pdat[i][phead[i]] : 8'h00;
    end
    fifo_full = full_pat[c];
  endtask

  task automatic run_cycles(input int n);
    logic [N-1:0] acc;
    for (int c = 0; c < n; c++) begin
      drive(c);
      @(negedge clk);
      lg_wr[c]  = {fifo_wr_en, fifo_data_in};
      lg_gv[c]  = grant_valid;
      lg_gid[c] = grant_id;
      lg_ptr[c] = dut.rr_ptr;
      lg_rdy[c] = req_ready;
      chk("wr_while_full", 32'(fifo_wr_en & fifo_full), 32'h0);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (acc[i]) phead[i]++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      plen[i]  = 0;
      phead[i] = 0;
    end
    for (int c = 0; c < 32; c++) full_pat[c] = 1'b0;
    drive(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gv",   32'(grant_valid),  32'h0);
    chk("rst_gid",  32'(grant_id),     32'h0);
    chk("rst_wr",   32'(fifo_wr_en),   32'h0);
    chk("rst_data", 32'(fifo_data_in), 32'h0);
    chk("rst_rdy",  32'(req_ready),    32'h0);
    chk("rst_ptr",  32'(dut.rr_ptr),   32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;

    // Single producer: 4-beat burst, bubble, then the fifth beat.
    do_reset();
    plen[0] = 5;
    pdat[0][0] = 8'h11; pdat[0][1] = 8'h22; pdat[0][2] = 8'h33;
    pdat[0][3] = 8'h44; pdat[0][4] = 8'h55;
    run_cycles(9);
    e9  = '{0, 'h111, 'h122, 'h133, 'h144, 0, 'h155, 0, 0};
    ev9 = '{0, 1, 1, 1, 1, 0, 1, 1, 0};
    for (int c = 0; c < 9; c++) begin
      chk($sformatf("t1_wr%0d", c), 32'(lg_wr[c]), e9[c]);
      chk($sformatf("t1_gv%0d", c), 32'(lg_gv[c]), ev9[c]);
    end

    // All four contend, two beats each.
    do_reset();
    for (int i = 0; i < N; i++) begin
      plen[i]    = 2;
      pdat[i][0] = 8'(i * 16);
      pdat[i][1] = 8'(i * 16 + 1);
    end
    run_cycles(17);
    for (int c = 0; c < 17; c++) e17[c] = 0;
    e17[1]  = 'h100; e17[2]  = 'h101; e17[5]  = 'h110; e17[6]  = 'h111;
    e17[9]  = 'h120; e17[10] = 'h121; e17[13] = 'h130; e17[14] = 'h131;
    cnt = 0;
    for (int c = 0; c < 17; c++) begin
      chk($sformatf("t2_wr%0d", c), 32'(lg_wr[c]), e17[c]);
      cnt += int'(lg_wr[c][8]);
    end
    chk("t2_pulses", cnt, 8);
    for (int g = 0; g < 4; g++) chk($sformatf("t2_gid%0d", g), 32'(lg_gid[1 + 4*g]), g);
    chk("t2_exit_gv", 32'(lg_gv[3]), 32'h1);
    chk("t2_bub4",    32'(lg_gv[4]), 32'h0);
    chk("t2_bub8",    32'(lg_gv[8]), 32'h0);
    chk("t2_bub12",   32'(lg_gv[12]), 32'h0);

    // Round-robin wrap: after a grant to 2, producers 0 and 3 compete.
    do_reset();
    plen[2] = 1; pdat[2][0] = 8'hA2;
    run_cycles(3);
    plen[0] = 1; pdat[0][0] = 8'hC0;
    plen[3] = 1; pdat[3][0] = 8'hB3;
    run_cycles(8);
    chk("t3_ptr_wrap", 32'(lg_ptr[0]), 32'h3);
    chk("t3_gid_first", 32'(lg_gid[1]), 32'h3);
    chk("t3_wr_first", 32'(lg_wr[1]), 32'h1B3);
    chk("t3_gid_second", 32'(lg_gid[4]), 32'h0);
    chk("t3_wr_second", 32'(lg_wr[4]), 32'h1C0);
    chk("t3_ptr_after", 32'(lg_ptr[6]), 32'h1);

    // Backpressure: full for three cycles mid-burst.
    do_reset();
    plen[1] = 4;
    pdat[1][0] = 8'hD0; pdat[1][1] = 8'hD1; pdat[1][2] = 8'hD2; pdat[1][3] = 8'hD3;
    full_pat[3] = 1'b1; full_pat[4] = 1'b1; full_pat[5] = 1'b1;
    run_cycles(9);
    e9  = '{0, 'h1D0, 'h1D1, 0, 0, 0, 'h1D2, 'h1D3, 0};
    ev9 = '{0, 2, 2, 0, 0, 0, 2, 2, 0};
    for (int c = 0; c < 9; c++) begin
      chk($sformatf("t4_wr%0d", c),  32'(lg_wr[c]),  e9[c]);
      chk($sformatf("t4_rdy%0d", c), 32'(lg_rdy[c]), ev9[c]);
    end
    chk("t4_hold_gv", 32'(lg_gv[4]), 32'h1);
    chk("t4_end_gv",  32'(lg_gv[8]), 32'h0);

    // Early end: producer 1 stops after two beats.
    do_reset();
    plen[1] = 2; pdat[1][0] = 8'hE0; pdat[1][1] = 8'hE1;
    run_cycles(5);
    chk("t5_wr1", 32'(lg_wr[1]), 32'h1E0);
    chk("t5_wr2", 32'(lg_wr[2]), 32'h1E1);
    chk("t5_wr3", 32'(lg_wr[3]), 32'h0);
    chk("t5_exit_gv", 32'(lg_gv[3]), 32'h1);
    chk("t5_idle_gv", 32'(lg_gv[4]), 32'h0);
    chk("t5_ptr", 32'(lg_ptr[4]), 32'h2);

    // Reset asserted during the second beat.
    do_reset();
    plen[0] = 4;
    pdat[0][0] = 8'hF0; pdat[0][1] = 8'hF1; pdat[0][2] = 8'hF2; pdat[0][3] = 8'hF3;
    run_cycles(2);
    drive(2);
    #1;
    chk("t6_beat2", 32'({fifo_wr_en, fifo_data_in}), 32'h1F1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_wr",   32'(fifo_wr_en),   32'h0);
    chk("t6_data", 32'(fifo_data_in), 32'h0);
    chk("t6_rdy",  32'(req_ready),    32'h0);
    chk("t6_gv",   32'(grant_valid),  32'h0);
    chk("t6_gid",  32'(grant_id),     32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < N; i++) plen[i] = 0;
    drive(0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t6_post_gv",  32'(grant_valid), 32'h0);
    chk("t6_post_ptr", 32'(dut.rr_ptr),  32'h0);
    chk("t6_post_wr",  32'(fifo_wr_en),  32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
